perceptron_introduction: RTL and testbench
==========================================

PERCEPTRON_INTRODUCTION -- requirements
Module: perceptron_introduction

Interface
REQ-001 Parameter size, default 2, number of inputs per sample (and number of weights).
REQ-002 Parameter num, default 4, number of training samples.
REQ-003 One clock; reset is asynchronous and active-high. The ports are named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 values  input  sfp[size]  inference operand vector.
REQ-007 activation  input  act_func  activation selector.
REQ-008 training  input  1  request to start a training run.
REQ-009 epochs  input  int (32 bits, signed)  number of passes over the training set.
REQ-010 learning_rate  input  sfp  learning-rate scale.
REQ-011 train_values  input  sfp[num][size]  training input vectors.
REQ-012 expected  input  sfp[num]  target output for each sample.
REQ-013 prediction  output  sfp  registered inference result.
REQ-014 done_training  output  1  high once training has completed.

Function
REQ-015 The sfp type SHALL be 32-bit signed fixed point Q16.16, so ONE = 32'h0001_0000.
REQ-016 Fixed-point multiply SHALL compute a 64-bit product, arithmetic-shift it right by 16, and saturate the result to the 32-bit signed range.
REQ-017 All sums SHALL saturate to the 32-bit signed range.
REQ-018 The net value SHALL be net(x) = bias + the sum over i of mul(w[i], x[i]).
REQ-019 The act_func enum SHALL define the following activations:
- Heaviside_Step: ONE if net > 0, else 0.
- ReLU: net if net > 0, else 0.
- Identity: net.
REQ-020 The FSM SHALL have three states, IDLE, TRAIN and DONE, with these transitions:
- IDLE -> TRAIN on a clock edge where training = 1.
- In IDLE and TRAIN, done_training = 0.
REQ-021 On entry to TRAIN, the block SHALL clear all weights, the bias, the epoch counter and the sample index to 0; no update occurs on that entry edge.
REQ-022 In TRAIN, each clock SHALL process exactly one sample k, taken in index order 0..num-1, with epochs evaluated as a signed value:
- y = act(net(train_values[k])).
- err = expected[k] - y.
- d = mul(learning_rate, err).
- w[i] += mul(d, train_values[k][i]).
- bias += d.
REQ-023 After sample num-1, the sample index SHALL wrap to 0 and the epoch counter SHALL increment.
REQ-024 When epochs*num updates have been committed, the FSM SHALL move to DONE and done_training SHALL rise on the edge that commits the last update.
REQ-025 If epochs <= 0, TRAIN SHALL go to DONE on its first edge with no update, leaving the weights at 0.
REQ-026 Once the FSM leaves IDLE, training SHALL be ignored: deasserting it mid-run does not abort.
REQ-027 DONE SHALL hold the weights and done_training = 1 until reset; retraining requires a reset.
REQ-028 prediction SHALL be registered every cycle in all states as act(net(values)) using the current weights and bias, giving one cycle of latency from values.

Reset
REQ-029 Asserting reset SHALL immediately force state = IDLE, weights = 0, bias = 0, counters = 0, prediction = 0 and done_training = 0.
REQ-030 Asserting reset mid-training SHALL discard all progress.

Structure
REQ-031 A shared package SHALL provide the sfp typedef, the act_func enum, the ONE constant, and the functions int_to_sfp, sfp_mul (saturating) and sfp_add (saturating).
REQ-032 One sub-module, perceptron_neuron, SHALL be combinational, computing act(net(x)) from the weights, bias, x and activation.
REQ-033 perceptron_neuron SHALL be instantiated twice: once for the training sample and once for the inference values.

Verification
REQ-034 AND: ONE = 0x10000, Heaviside_Step, learning_rate = ONE, epochs = 5, training samples {(1,1),(1,0),(0,1),(0,0)} with expected {1,0,0,0} -> done_training rises 21 edges after training is first sampled; final weights (1,2) and bias -2 in ONE units; prediction equals ONE only for values (1,1).
REQ-035 OR: same setup with expected {1,1,1,0} -> after done_training, prediction equals ONE for every input except (0,0).
REQ-036 XOR: expected {0,1,1,0}, epochs = 5 -> done_training still asserts after 20 updates; at least one of the four inputs mispredicts.
REQ-037 epochs = 0 -> done_training = 1 one edge after entering TRAIN; weights 0; prediction = 0 under Heaviside_Step.
REQ-038 Reset asserted mid-epoch (after update 7) -> done_training = 0 and prediction = 0 immediately; with training held high after release, a fresh run completes after 21 edges.
REQ-039 Saturation: Identity activation, w = 0x7FFF0000, values = 0x7FFF0000 -> prediction = 0x7FFFFFFF with no wrap.

Source files
------------

// File: rtl/perceptron_introduction_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// perceptron_introduction_pkg : Q16.16 types, activation enum, FSM states and
//                               saturating fixed-point arithmetic helpers.
// Rev 1.0
// ----------------------------------------------------------------------------
package perceptron_introduction_pkg;

   typedef logic signed [31:0] sfp;

   typedef enum logic [1:0] {
      Heaviside_Step = 2'd0,
      ReLU           = 2'd1,
      Identity       = 2'd2
   } act_func;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRAIN = 2'd1,
      DONE  = 2'd2
   } train_state_t;

   localparam sfp ONE     = 32'sh0001_0000;
   localparam sfp SFP_MAX = 32'sh7FFF_FFFF;
   localparam sfp SFP_MIN = 32'sh8000_0000;

   function automatic sfp sat64(input logic signed [63:0] v);
      sfp r;
      if (v > 64'sh0000_0000_7FFF_FFFF)      r = SFP_MAX;
      else if (v < 64'shFFFF_FFFF_8000_0000) r = SFP_MIN;
      else                                   r = v[31:0];
      return r;
   endfunction

   // A 33-bit result whose top two bits disagree has left the 32-bit range.
   function automatic sfp sat33(input logic signed [32:0] v);
      sfp r;
      if (v[32] != v[31]) r = v[32] ? SFP_MIN : SFP_MAX;
      else                r = v[31:0];
      return r;
   endfunction

   function automatic sfp int_to_sfp(input int v);
      logic signed [63:0] t;
      t = {{32{v[31]}}, v};
      return sat64(t <<< 16);
   endfunction

   function automatic sfp sfp_mul(input sfp a, input sfp b);
      logic signed [63:0] wa;
      logic signed [63:0] wb;
      logic signed [63:0] p;
      wa = {{32{a[31]}}, a};
      wb = {{32{b[31]}}, b};
      p  = wa * wb;
      return sat64(p >>> 16);
   endfunction

   function automatic sfp sfp_add(input sfp a, input sfp b);
      logic signed [32:0] s;
      s = {a[31], a} + {b[31], b};
      return sat33(s);
   endfunction

   function automatic sfp sfp_sub(input sfp a, input sfp b);
      logic signed [32:0] s;
      s = {a[31], a} - {b[31], b};
      return sat33(s);
   endfunction

endpackage

`default_nettype wire

// File: rtl/perceptron_neuron.sv
`default_nettype none
// ----------------------------------------------------------------------------
// perceptron_neuron : combinational act(bias + sum(w[i]*x[i])) in Q16.16.
// Rev 1.0
// ----------------------------------------------------------------------------
module perceptron_neuron
   import perceptron_introduction_pkg::*;
#(
   parameter int size = 2
) (
   input  logic [size-1:0][31:0] weights,
   input  logic signed [31:0]    bias,
   input  logic [size-1:0][31:0] x,
   input  act_func               activation,
   output logic signed [31:0]    y
);

   sfp w_net;

   // Accumulate left to right from the bias, saturating at every step.
   always_comb begin
      w_net = bias;
      for (int i = 0; i < size; i++) begin
         w_net = sfp_add(w_net, sfp_mul(weights[i], x[i]));
      end
      y = '0;
      case (activation)
         Heaviside_Step: y = (w_net > 32'sd0) ? ONE : '0;
         ReLU:           y = (w_net > 32'sd0) ? w_net : '0;
         Identity:       y = w_net;
         default:        y = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/perceptron_introduction.sv
`default_nettype none
// ----------------------------------------------------------------------------
// perceptron_introduction : single-layer perceptron, one sample per clock
//                           training FSM plus registered inference.
// Rev 1.0
// ----------------------------------------------------------------------------
module perceptron_introduction
   import perceptron_introduction_pkg::*;
#(
   parameter int size = 2,
   parameter int num  = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [size-1:0][31:0]          values,
   input  act_func                        activation,
   input  logic                           training,
   input  logic signed [31:0]             epochs,
   input  logic signed [31:0]             learning_rate,
   input  logic [num-1:0][size-1:0][31:0] train_values,
   input  logic [num-1:0][31:0]           expected,
   output logic signed [31:0]             prediction,
   output logic                           done_training
);

   localparam int IDX_W = (num > 1) ? $clog2(num) : 1;

   train_state_t           r_state;
   train_state_t           w_state_next;
   logic [size-1:0][31:0]  r_weights;
   logic [size-1:0][31:0]  w_new_weights;
   sfp                     r_bias;
   sfp                     w_new_bias;
   logic signed [31:0]     r_epoch_cnt;
   logic [IDX_W-1:0]       r_sample_idx;
   sfp                     r_prediction;
   sfp                     w_train_y;
   sfp                     w_infer_y;
   sfp                     w_err;
   sfp                     w_delta;
   logic [size-1:0][31:0]  w_sample;
   logic                   w_run_empty;
   logic                   w_last_sample;
   logic                   w_last_update;

   assign w_sample = train_values[r_sample_idx];

   perceptron_neuron #(.size(size)) u_train_neuron (
      .weights    (r_weights),
      .bias       (r_bias),
      .x          (w_sample),
      .activation (activation),
      .y          (w_train_y)
   );

   perceptron_neuron #(.size(size)) u_infer_neuron (
      .weights    (r_weights),
      .bias       (r_bias),
      .x          (values),
      .activation (activation),
      .y          (w_infer_y)
   );

   always_comb begin
      w_err      = sfp_sub(expected[r_sample_idx], w_train_y);
      w_delta    = sfp_mul(learning_rate, w_err);
      w_new_bias = sfp_add(r_bias, w_delta);
      for (int i = 0; i < size; i++) begin
         w_new_weights[i] = sfp_add(r_weights[i], sfp_mul(w_delta, w_sample[i]));
      end
   end

   // The last update is the final sample of epoch epochs-1; epochs <= 0 is
   // caught separately so epochs-1 never underflows in the compare.
   assign w_run_empty   = (epochs <= 32'sd0);
   assign w_last_sample = (r_sample_idx == IDX_W'(num - 1));
   assign w_last_update = w_last_sample && (r_epoch_cnt >= (epochs - 32'sd1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (training) w_state_next = TRAIN;
         TRAIN:   if (w_run_empty || w_last_update) w_state_next = DONE;
         DONE:    w_state_next = DONE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_weights    <= '0;
         r_bias       <= '0;
         r_epoch_cnt  <= '0;
         r_sample_idx <= '0;
         r_prediction <= '0;
      end else begin
         r_prediction <= w_infer_y;
         case (r_state)
            IDLE: begin
               if (training) begin
                  r_weights    <= '0;
                  r_bias       <= '0;
                  r_epoch_cnt  <= '0;
                  r_sample_idx <= '0;
               end
            end
            TRAIN: begin
               if (!w_run_empty) begin
                  r_weights <= w_new_weights;
                  r_bias    <= w_new_bias;
                  if (w_last_sample) begin
                     r_sample_idx <= '0;
                     r_epoch_cnt  <= r_epoch_cnt + 32'sd1;
                  end else begin
                     r_sample_idx <= r_sample_idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign prediction    = r_prediction;
   assign done_training = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_perceptron_introduction.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_perceptron_introduction : directed and randomized training runs checked
//                              against a loop-based Q16.16 perceptron model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_perceptron_introduction;
   import perceptron_introduction_pkg::*;

   localparam int SIZE = 2;
   localparam int NUM  = 4;
   localparam logic [31:0] O = 32'h0001_0000;
   localparam longint L_MAX = 64'sd2147483647;
   localparam longint L_MIN = -64'sd2147483648;

   logic                           clk = 1'b0;
   logic                           reset = 1'b0;
   logic [SIZE-1:0][31:0]          values = '0;
   act_func                        activation = Heaviside_Step;
   logic                           training = 1'b0;
   logic signed [31:0]             epochs = '0;
   logic signed [31:0]             learning_rate = '0;
   logic [NUM-1:0][SIZE-1:0][31:0] train_values = '0;
   logic [NUM-1:0][31:0]           expected = '0;
   logic signed [31:0]             prediction;
   logic                           done_training;

   int     checks = 0;
   int     errors = 0;
   longint m_w[SIZE];
   longint m_b;

   perceptron_introduction #(.size(SIZE), .num(NUM)) dut (
      .clk           (clk),
      .reset         (reset),
      .values        (values),
      .activation    (activation),
      .training      (training),
      .epochs        (epochs),
      .learning_rate (learning_rate),
      .train_values  (train_values),
      .expected      (expected),
      .prediction    (prediction),
      .done_training (done_training)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (plain integer arithmetic) ----------
   function automatic longint sx(input logic [31:0] v);
      return longint'(signed'(v));
   endfunction

   function automatic longint m_sat(input longint v);
      if (v > L_MAX) return L_MAX;
      if (v < L_MIN) return L_MIN;
      return v;
   endfunction

   function automatic longint m_mul(input longint a, input longint b);
      return m_sat((a * b) >>> 16);
   endfunction

   function automatic longint m_add(input longint a, input longint b);
      return m_sat(a + b);
   endfunction

   function automatic longint m_act(input longint net, input act_func a);
      case (a)
         Heaviside_Step: return (net > 0) ? 64'sd65536 : 64'sd0;
         ReLU:           return (net > 0) ? net : 64'sd0;
         Identity:       return net;
         default:        return 64'sd0;
      endcase
   endfunction

   function automatic longint m_net(input logic [31:0] x0, input logic [31:0] x1);
      longint acc;
      acc = m_b;
      acc = m_add(acc, m_mul(m_w[0], sx(x0)));
      acc = m_add(acc, m_mul(m_w[1], sx(x1)));
      return acc;
   endfunction

   function automatic logic [31:0] m_pred(input logic [31:0] x0, input logic [31:0] x1);
      return 32'(m_act(m_net(x0, x1), activation));
   endfunction

   task automatic model_train();
      longint y, err, d;
      for (int i = 0; i < SIZE; i++) m_w[i] = 0;
      m_b = 0;
      for (int e = 0; e < epochs; e++) begin
         for (int k = 0; k < NUM; k++) begin
            y   = m_act(m_net(train_values[k][0], train_values[k][1]), activation);
            err = m_sat(sx(expected[k]) - y);
            d   = m_mul(sx(learning_rate), err);
            for (int i = 0; i < SIZE; i++)
               m_w[i] = m_add(m_w[i], m_mul(d, sx(train_values[k][i])));
            m_b = m_add(m_b, d);
         end
      end
   endtask

   // ---------------- helpers ----------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called one unit after an edge; reset stays high for two units.
   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      check({tag, "_rst_done"}, 32'(done_training), 32'd0);
      check({tag, "_rst_pred"}, prediction, 32'd0);
      #1;
      reset = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lat, input bit drop);
      int edges;
      edges = 0;
      do begin
         tick();
         edges++;
         if (drop && edges == 1) training = 1'b0;
      end while (done_training !== 1'b1 && edges < 400);
      check({tag, "_latency"}, 32'(edges), 32'(lat));
   endtask

   task automatic check_pred(input string tag, input logic [31:0] x0, input logic [31:0] x1,
                             input logic [31:0] exp);
      values[0] = x0;
      values[1] = x1;
      tick();
      check(tag, prediction, exp);
   endtask

   task automatic set_samples(input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
      train_values[0][0] = O;  train_values[0][1] = O;
      train_values[1][0] = O;  train_values[1][1] = 0;
      train_values[2][0] = 0;  train_values[2][1] = O;
      train_values[3][0] = 0;  train_values[3][1] = 0;
      expected[0] = e0; expected[1] = e1; expected[2] = e2; expected[3] = e3;
   endtask

   function automatic logic [31:0] rnd_small();
      return 32'($urandom_range(0, 262144)) - 32'd131072;
   endfunction

   // ---------------- directed and random sequence ------------------------
   initial begin
      int mis;
      int ep;
      logic [31:0] tgt[4];
      logic [31:0] a, b;

      #1;
      do_reset("init");

      // AND
      learning_rate = O; activation = Heaviside_Step; epochs = 5;
      set_samples(O, 0, 0, 0);
      training = 1'b1;
      wait_done("and", 21, 1'b1);
      model_train();
      check_pred("and_11", O, O, O);
      check_pred("and_10", O, 0, 32'd0);
      check_pred("and_01", 0, O, 32'd0);
      check_pred("and_00", 0, 0, 32'd0);
      activation = Identity;
      check_pred("and_net_11", O, O, m_pred(O, O));
      check_pred("and_net_00", 0, 0, 32'hFFFE_0000);
      activation = Heaviside_Step;
      training = 1'b1;
      tick(); tick(); tick();
      training = 1'b0;
      check("and_hold_done", 32'(done_training), 32'd1);
      check_pred("and_hold_11", O, O, O);

      // OR
      do_reset("or");
      set_samples(O, O, O, 0);
      training = 1'b1;
      wait_done("or", 21, 1'b1);
      model_train();
      check_pred("or_11", O, O, O);
      check_pred("or_10", O, 0, O);
      check_pred("or_01", 0, O, O);
      check_pred("or_00", 0, 0, 32'd0);

      // XOR cannot be learned, but the run still terminates
      do_reset("xor");
      set_samples(0, O, O, 0);
      training = 1'b1;
      wait_done("xor", 21, 1'b1);
      tgt[0] = 0; tgt[1] = O; tgt[2] = O; tgt[3] = 0;
      mis = 0;
      for (int k = 0; k < NUM; k++) begin
         values[0] = train_values[k][0];
         values[1] = train_values[k][1];
         tick();
         if (prediction !== tgt[k]) mis++;
      end
      check("xor_mispredict", 32'((mis > 0) ? 1 : 0), 32'd1);

      // Zero and negative epoch counts finish on the first TRAIN edge
      do_reset("ep0");
      epochs = 0;
      training = 1'b1;
      wait_done("ep0", 2, 1'b1);
      check_pred("ep0_pred", O, O, 32'd0);
      do_reset("epneg");
      epochs = -3;
      training = 1'b1;
      wait_done("epneg", 2, 1'b1);
      check_pred("epneg_pred", O, O, 32'd0);

      // Reset after the seventh update, training held high throughout
      do_reset("mid_pre");
      epochs = 5;
      set_samples(O, 0, 0, 0);
      training = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) tick();
      check("mid_running", 32'(done_training), 32'd0);
      do_reset("mid");
      wait_done("mid_rerun", 21, 1'b0);
      training = 1'b0;
      model_train();
      check_pred("mid_11", O, O, O);
      check_pred("mid_10", O, 0, m_pred(O, 0));

      // Saturation: drive w0 and bias to 0x7FFF0000 with Identity
      do_reset("sat");
      activation = Identity; epochs = 1; learning_rate = O;
      train_values = '0;
      train_values[0][0] = O;
      for (int k = 0; k < NUM; k++) expected[k] = 32'h7FFF_0000;
      training = 1'b1;
      wait_done("sat", 5, 1'b1);
      model_train();
      check_pred("sat_pos", 32'h7FFF_0000, 0, 32'h7FFF_FFFF);
      check_pred("sat_neg", 32'h8000_0000, 0, m_pred(32'h8000_0000, 0));

      // Randomized runs
      for (int r = 0; r < 5; r++) begin
         do_reset("rnd");
         for (int k = 0; k < NUM; k++) begin
            for (int i = 0; i < SIZE; i++) train_values[k][i] = rnd_small();
            expected[k] = rnd_small();
         end
         learning_rate = 32'($urandom_range(0, 32768));
         activation    = act_func'(2'($urandom_range(0, 2)));
         ep            = (r == 0) ? -1 : int'($urandom_range(0, 3));
         epochs        = ep;
         training = 1'b1;
         wait_done("rnd", (ep <= 0) ? 2 : ep * NUM + 1, 1'b1);
         model_train();
         for (int j = 0; j < 3; j++) begin
            activation = act_func'(2'($urandom_range(0, 2)));
            a = (j == 2) ? 32'($urandom) : rnd_small();
            b = (j == 2) ? 32'($urandom) : rnd_small();
            check_pred("rnd_pred", a, b, m_pred(a, b));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
